input_conditioner: RTL
======================

Name: input_conditioner

Overview:
- Conditions up to WIDTH asynchronous board inputs (push-buttons, switches) for the single-cycle core's IO subsystem.
- Passes each input through the existing two-flop synchronizer, then debounces it.
- Debounce uses one shared sample-pulse scheduler and a per-channel saturating counter.
- Emits a debounced level per channel and a one-cycle rising-edge pulse per channel; MMIO and control logic consume these.

Parameters:
- WIDTH, 1, number of independent input channels.
- SAMPLE_CNT_MAX, 62500, clock cycles between sample pulses (0.5 ms at 125 MHz); must be >= 2.
- PULSE_CNT_MAX, 200, consecutive high samples required to declare a channel pressed; must be >= 1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- async_in, input, WIDTH, raw asynchronous inputs.
- level_out, output, WIDTH, debounced level per channel.
- rise_pulse, output, WIDTH, one-cycle pulse on each debounced 0->1 transition.

Behaviour:
- Interface (fixed):
  - One clock domain, clk.
  - Reset rst_n is asynchronous and active-low; it clears all block-owned state immediately on assertion.
- Synchronizer stage:
  - async_in feeds a synchronizer of width WIDTH, adding 2 cycles of latency.
  - Synchronizer flops are not reset; they are initialised to 0 in simulation.
- Sample scheduler:
  - Counter runs 0..SAMPLE_CNT_MAX-1, width $clog2(SAMPLE_CNT_MAX), and wraps to 0.
  - sample_pulse is high for exactly the one cycle in which the counter equals SAMPLE_CNT_MAX-1.
  - Counter free-runs; one scheduler is shared by all channels.
- Per-channel saturating counter (width $clog2(PULSE_CNT_MAX+1)):
  - Synced bit = 0: counter cleared to 0 on the next edge, regardless of sample_pulse.
  - Synced bit = 1, sample_pulse = 1, counter < PULSE_CNT_MAX: counter increments.
  - Synced bit = 1, counter = PULSE_CNT_MAX: counter holds (saturates); no wrap.
  - Clear and increment never coincide: clear takes priority because it depends on synced = 0.
- level_out[i] = (counter[i] == PULSE_CNT_MAX), decoded directly from the register, with no extra latency.
- Edge detect:
  - prev[i] registers level_out[i].
  - rise_pulse[i] = level_out[i] & ~prev[i], high for exactly one cycle per press.
- Press latency:
  - Synced rise to level_out rise is between (PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX+1 and PULSE_CNT_MAX*SAMPLE_CNT_MAX cycles.
  - Add 2 cycles for the synchronizer.
- Release latency: level_out falls 1 cycle after the synced bit falls (3 cycles after async_in falls).
- Reset values: scheduler counter, all channel counters and prev = 0, so level_out = 0 and rise_pulse = 0.
- Reset mid-operation:
  - All progress is lost.
  - An input held through reset must re-qualify for the full debounce time, then produces a new rise_pulse.
- Simultaneous presses:
  - Channels are independent.
  - Channels sharing a sample_pulse may assert rise_pulse in the same cycle.

Optional Feature:
- Macro: INPUT_COND_FALL_EDGE_EN.
- Defined:
  - Adds output fall_pulse (WIDTH).
  - fall_pulse[i] = ~level_out[i] & prev[i], one cycle per release.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package io_cond_pkg holds:
  - Default constants IO_COND_SAMPLE_CNT_MAX = 62500 and IO_COND_PULSE_CNT_MAX = 200.
  - Helper localparam widths.
- Sub-module debounce_channel, instantiated WIDTH times via generate:
  - Holds one saturating counter, the level decode, prev, and the edge outputs.
  - Inputs: clk, rst_n, sync bit, sample_pulse.
- The scheduler and synchronizer instance stay in the top level.

Test Plan (SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, WIDTH=2 unless noted):
- Reset release with async_in=00, run 20 cycles -> sample_pulse every 4th cycle; level_out=00 and rise_pulse=00 throughout.
- async_in[0] 0->1 held -> level_out[0] rises 11..14 cycles later; rise_pulse[0] high exactly 1 cycle; channel 1 untouched.
- Bounce: async_in[0]=1 for 6 cycles then 0, repeated 5 times -> counter never reaches 3; level_out[0] and rise_pulse[0] stay 0.
- Release after qualified press -> level_out[0] falls exactly 3 cycles after async_in[0] falls; no rise_pulse; with INPUT_COND_FALL_EDGE_EN, fall_pulse[0] high 1 cycle in that cycle.
- Both channels rise in the same cycle -> rise_pulse=11 in a single cycle.
- rst_n pulsed low mid-count, input held high -> outputs 0 immediately and asynchronously; after release, full 11..14-cycle re-qualification, then one rise_pulse.

Source files
------------

// File: rtl/io_cond_pkg.sv
// io_cond_pkg: shared constants and width helper for input_conditioner.
// Optional fall-edge output is enabled by INPUT_COND_FALL_EDGE_EN.
package io_cond_pkg;

  localparam int unsigned IO_COND_SAMPLE_CNT_MAX = 62500;
  localparam int unsigned IO_COND_PULSE_CNT_MAX  = 200;

  // Bits needed to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned IO_COND_SAMPLE_W =
    cnt_w(IO_COND_SAMPLE_CNT_MAX);
  localparam int unsigned IO_COND_PULSE_W  =
    cnt_w(IO_COND_PULSE_CNT_MAX + 1);

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one saturating debounce counter, level decode, edge pulses.
// Ports: clk, rst_n, sync_i, sample_i -> level_o, rise_o (+fall_o if INPUT_COND_FALL_EDGE_EN).
module debounce_channel
  import io_cond_pkg::*;
#(
  parameter int unsigned PULSE_CNT_MAX = IO_COND_PULSE_CNT_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_i,
  input  logic sample_i,
  output logic level_o,
  output logic rise_o
`ifdef INPUT_COND_FALL_EDGE_EN
  ,
  output logic fall_o
`endif
);

  localparam int unsigned PW = cnt_w(PULSE_CNT_MAX + 1);
  localparam logic [PW-1:0] CMAX = PW'(PULSE_CNT_MAX);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          prev_q;

  // A low synced bit always wins, so a single glitch low restarts
  // qualification from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync_i) begin
      cnt_d = '0;
    end else if (sample_i && (cnt_q != CMAX)) begin
      cnt_d = cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= level_o;
    end
  end

  assign level_o = (cnt_q == CMAX);
  assign rise_o  = level_o & ~prev_q;
`ifdef INPUT_COND_FALL_EDGE_EN
  assign fall_o  = ~level_o & prev_q;
`endif

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: 2-flop sync, shared sample scheduler, per-channel debounce.
// Ports: clk, rst_n, async_in[W] -> level_out[W], rise_pulse[W]; fall_pulse[W] if INPUT_COND_FALL_EDGE_EN.
module input_conditioner
  import io_cond_pkg::*;
#(
  parameter int unsigned WIDTH          = 1,
  parameter int unsigned SAMPLE_CNT_MAX = IO_COND_SAMPLE_CNT_MAX,
  parameter int unsigned PULSE_CNT_MAX  = IO_COND_PULSE_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse
`ifdef INPUT_COND_FALL_EDGE_EN
  ,
  output logic [WIDTH-1:0] fall_pulse
`endif
);

  localparam int unsigned SW = cnt_w(SAMPLE_CNT_MAX);
  localparam logic [SW-1:0] SLAST = SW'(SAMPLE_CNT_MAX - 1);

  // Synchronizer flops carry no reset; they power up at zero.
  logic [WIDTH-1:0] meta_q = '0;
  logic [WIDTH-1:0] sync_q = '0;

  always_ff @(posedge clk) begin
    meta_q <= async_in;
    sync_q <= meta_q;
  end

  logic [SW-1:0] sched_q, sched_d;
  logic          sample_pulse;

  assign sample_pulse = (sched_q == SLAST);
  assign sched_d = sample_pulse ? '0 : sched_q + SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched_q <= '0;
    end else begin
      sched_q <= sched_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .PULSE_CNT_MAX(PULSE_CNT_MAX)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .sync_i  (sync_q[i]),
      .sample_i(sample_pulse),
      .level_o (level_out[i]),
      .rise_o  (rise_pulse[i])
`ifdef INPUT_COND_FALL_EDGE_EN
      ,
      .fall_o  (fall_pulse[i])
`endif
    );
  end

endmodule
